pll_drp_reconfig: RTL and testbench



---
 rtl/pll_drp_reconfig.sv | 191 +++++++++++++++++++
 tb/tb_pll_drp_reconfig.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_drp_reconfig.sv
// DRP read-modify-write initiator for a 7-series PLLE2_ADV output divider.
// Holds the PLL in reset, rewrites ClkReg1/ClkReg2, releases reset and waits for lock.
module pll_drp_reconfig #(
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        req,
  input  logic [2:0]  out_sel,
  input  logic [6:0]  divide,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  localparam int MAX_T = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CNT_W = $clog2(MAX_T + 1);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_RD1, S_WRD1, S_WR1, S_WWR1,
    S_RD2, S_WRD2, S_WR2, S_WWR2, S_REL, S_WLOCK
  } state_t;

  state_t           state;
  logic [2:0]       sel_q;
  logic [6:0]       div_q;
  logic [CNT_W-1:0] cnt;
  logic             locked_s1, locked_s2;

  logic [6:0]  reg1_addr;
  logic [6:0]  reg2_addr;
  logic [5:0]  high_cnt, low_cnt;
  logic        is_one, edge_bit;
  logic [15:0] reg1_data, reg2_data;
  logic        bad_req;
  logic        unused_do;

  // The low read-back bits are overwritten by the new divider fields, never merged.
  assign unused_do = ^drp_do[7:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    reg1_addr = 7'h14;
    unique case (sel_q)
      3'd0: reg1_addr = 7'h08;
      3'd1: reg1_addr = 7'h0A;
      3'd2: reg1_addr = 7'h0C;
      3'd3: reg1_addr = 7'h0E;
      3'd4: reg1_addr = 7'h10;
      3'd5: reg1_addr = 7'h06;
      default: reg1_addr = 7'h14;
    endcase
  end

  assign reg2_addr = reg1_addr + 7'd1;
  assign is_one    = (div_q == 7'd1);
  // Divide-by-1 bypasses the counter, so high/low are forced to 1 and edge is unused.
  assign high_cnt  = is_one ? 6'd1 : div_q[6:1];
  assign low_cnt   = is_one ? 6'd1 : div_q[6:1] + {5'd0, div_q[0]};
  assign edge_bit  = div_q[0] & ~is_one;
  // Write data merges straight from drp_do so the write can issue the cycle after drdy.
  assign reg1_data = {drp_do[15:12], high_cnt, low_cnt};
  assign reg2_data = {drp_do[15:8], edge_bit, is_one, 6'd0};
  assign bad_req   = (divide == 7'd0) || (divide == 7'd127) || (out_sel == 3'd7);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      locked_s1 <= 1'b0;
      locked_s2 <= 1'b0;
    end else begin
      locked_s1 <= pll_locked;
      locked_s2 <= locked_s1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      sel_q     <= 3'd0;
      div_q     <= 7'd0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      drp_daddr <= 7'd0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_di    <= 16'd0;
      pll_rst   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; pulses default low each cycle.
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req && bad_req) begin
            err <= 1'b1;
          end else if (req) begin
            sel_q   <= out_sel;
            div_q   <= divide;
            busy    <= 1'b1;
            pll_rst <= 1'b1;
            state   <= S_RST;
          end
        end
        S_RST: begin
          drp_den   <= 1'b1;
          drp_dwe   <= 1'b0;
          drp_daddr <= reg1_addr;
          state     <= S_RD1;
        end
        S_RD1, S_WR1, S_RD2, S_WR2: begin
          drp_den <= 1'b0;
          drp_dwe <= 1'b0;
          cnt     <= '0;
          unique case (state)
            S_RD1:   state <= S_WRD1;
            S_WR1:   state <= S_WWR1;
            S_RD2:   state <= S_WRD2;
            default: state <= S_WWR2;
          endcase
        end
        S_WRD1, S_WWR1, S_WRD2, S_WWR2: begin
          if (drp_drdy) begin
            cnt <= '0;
            unique case (state)
              S_WRD1: begin
                drp_den <= 1'b1;
                drp_dwe <= 1'b1;
                drp_di  <= reg1_data;
                state   <= S_WR1;
              end
              S_WWR1: begin
                drp_den   <= 1'b1;
                drp_daddr <= reg2_addr;
                state     <= S_RD2;
              end
              S_WRD2: begin
                drp_den <= 1'b1;
                drp_dwe <= 1'b1;
                drp_di  <= reg2_data;
                state   <= S_WR2;
              end
              default: begin
                pll_rst <= 1'b0;
                state   <= S_REL;
              end
            endcase
          end else if (cnt == DRDY_LAST) begin
            pll_rst <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_REL: begin
          cnt   <= '0;
          state <= S_WLOCK;
        end
        S_WLOCK: begin
          if (locked_s2) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt == LOCK_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Directed self-checking bench for pll_drp_reconfig: the bench plays the DRP slave
// and the PLL LOCKED pin, with hand-computed addresses, write data and timeouts.
module tb_pll_drp_reconfig;

  localparam int DRDY_T = 255;
  localparam int LOCK_T = 65535;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  out_sel = 3'd0;
  logic [6:0]  divide = 7'd0;
  logic        busy, done, err;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do = 16'h0000;
  logic        drp_drdy = 1'b0;
  logic        pll_rst;
  logic        pll_locked = 1'b0;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk_in = ~clk_in;

  pll_drp_reconfig #(.DRDY_TIMEOUT(DRDY_T), .LOCK_TIMEOUT(LOCK_T)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .req(req), .out_sel(out_sel), .divide(divide),
    .busy(busy), .done(done), .err(err), .drp_daddr(drp_daddr), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy),
    .pll_rst(pll_rst), .pll_locked(pll_locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " den"}, 32'(drp_den), 32'd0);
    check({tag, " dwe"}, 32'(drp_dwe), 32'd0);
    check({tag, " daddr"}, 32'(drp_daddr), 32'd0);
    check({tag, " di"}, 32'(drp_di), 32'd0);
    check({tag, " pll_rst"}, 32'(pll_rst), 32'd0);
  endtask

  task automatic wait_den(input string tag);
    int n = 0;
    while (drp_den !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " den seen"}, 32'(drp_den), 32'd1);
  endtask

  // Request accepted at edge N: busy/pll_rst visible after N, first den after N+1.
  task automatic start_req(input string tag, input logic [2:0] sel, input logic [6:0] div);
    out_sel = sel;
    divide  = div;
    req     = 1'b1;
    tick();
    req = 1'b0;
    check({tag, " busy N+1"}, 32'(busy), 32'd1);
    check({tag, " pll_rst N+1"}, 32'(pll_rst), 32'd1);
    check({tag, " den N+1"}, 32'(drp_den), 32'd0);
    tick();
    check({tag, " den N+2"}, 32'(drp_den), 32'd1);
  endtask

  task automatic serve(input string tag, input logic is_write, input logic [6:0] addr,
                       input logic [15:0] wdata, input logic [15:0] rdata, input int lat);
    wait_den(tag);
    check({tag, " addr"}, 32'(drp_daddr), 32'(addr));
    check({tag, " dwe"}, 32'(drp_dwe), 32'(is_write));
    if (is_write) check({tag, " wdata"}, 32'(drp_di), 32'(wdata));
    check({tag, " pll_rst"}, 32'(pll_rst), 32'd1);
    tick();
    check({tag, " den width"}, 32'(drp_den), 32'd0);
    repeat (lat - 1) tick();
    drp_drdy = 1'b1;
    drp_do   = rdata;
    tick();
    drp_drdy = 1'b0;
    drp_do   = 16'hDEAD;
  endtask

  task automatic run_valid(input string tag, input logic [2:0] sel, input logic [6:0] div,
                           input logic [6:0] a1, input logic [6:0] a2,
                           input logic [15:0] r1, input logic [15:0] w1,
                           input logic [15:0] r2, input logic [15:0] w2,
                           input int lat, input logic poke);
    int dens;
    pll_locked = 1'b0;
    start_req(tag, sel, div);
    if (poke) req = 1'b1;
    serve({tag, " rd1"}, 1'b0, a1, 16'h0, r1, lat);
    req = 1'b0;
    serve({tag, " wr1"}, 1'b1, a1, w1, 16'h0, lat);
    serve({tag, " rd2"}, 1'b0, a2, 16'h0, r2, lat);
    serve({tag, " wr2"}, 1'b1, a2, w2, 16'h0, lat);
    check({tag, " pll_rst released"}, 32'(pll_rst), 32'd0);
    check({tag, " busy in lock wait"}, 32'(busy), 32'd1);
    tick();
    pll_locked = 1'b1;
    tick(2);
    check({tag, " done before sync"}, 32'(done), 32'd0);
    tick();
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy with done"}, 32'(busy), 32'd0);
    check({tag, " err with done"}, 32'(err), 32'd0);
    tick();
    check({tag, " done width"}, 32'(done), 32'd0);
    if (poke) begin
      dens = 0;
      repeat (30) begin
        tick();
        if (drp_den === 1'b1) dens++;
      end
      check({tag, " no queued req"}, 32'(dens), 32'd0);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic invalid_req(input string tag, input logic [2:0] sel, input logic [6:0] div);
    out_sel = sel;
    divide  = div;
    req     = 1'b1;
    tick();
    req = 1'b0;
    check({tag, " err N+1"}, 32'(err), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " pll_rst"}, 32'(pll_rst), 32'd0);
    check({tag, " den"}, 32'(drp_den), 32'd0);
    tick();
    check({tag, " err width"}, 32'(err), 32'd0);
    check({tag, " den after"}, 32'(drp_den), 32'd0);
  endtask

  task automatic count_to_err(input string tag, input int exp_cycles);
    int c = 0;
    while (err !== 1'b1 && c < exp_cycles + 50) begin
      tick();
      c++;
    end
    check({tag, " cycles to err"}, 32'(c), 32'(exp_cycles));
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " pll_rst"}, 32'(pll_rst), 32'd0);
    check({tag, " den"}, 32'(drp_den), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    tick();
    check({tag, " err width"}, 32'(err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(2);
    check_quiet("reset");
    reset_n = 1'b1;
    tick(2);

    // divide=20: high=low=10, edge=0
    run_valid("d20", 3'd0, 7'd20, 7'h08, 7'h09, 16'hF3CF, 16'hF28A, 16'hAB55, 16'hAB00, 1, 1'b0);
    // divide=5: high=2, low=3, edge=1; req re-pulsed while busy
    run_valid("d5", 3'd2, 7'd5, 7'h0C, 7'h0D, 16'h0000, 16'h0083, 16'h0000, 16'h0080, 3, 1'b1);
    // divide=1: bypass, nocount=1
    run_valid("d1", 3'd6, 7'd1, 7'h14, 7'h15, 16'h1000, 16'h1041, 16'h0000, 16'h0040, 2, 1'b0);
    // divide=126: high=low=63
    run_valid("d126", 3'd5, 7'd126, 7'h06, 7'h07, 16'h0000, 16'h0FFF, 16'h00FF, 16'h0000, 1, 1'b0);
    // divide=3: high=1, low=2, edge=1
    run_valid("d3", 3'd4, 7'd3, 7'h10, 7'h11, 16'h0000, 16'h0042, 16'h0000, 16'h0080, 1, 1'b0);

    invalid_req("div0", 3'd0, 7'd0);
    invalid_req("div127", 3'd1, 7'd127);
    invalid_req("sel7", 3'd7, 7'd5);

    pll_locked = 1'b0;
    start_req("drdy_to", 3'd1, 7'd10);
    check("drdy_to addr", 32'(drp_daddr), 32'h0A);
    count_to_err("drdy_to", DRDY_T + 1);

    start_req("lock_to", 3'd1, 7'd7);
    serve("lock_to rd1", 1'b0, 7'h0A, 16'h0, 16'h0000, 1);
    serve("lock_to wr1", 1'b1, 7'h0A, 16'h00C4, 16'h0, 1);
    serve("lock_to rd2", 1'b0, 7'h0B, 16'h0, 16'h0000, 1);
    serve("lock_to wr2", 1'b1, 7'h0B, 16'h0080, 16'h0, 1);
    count_to_err("lock_to", LOCK_T + 1);

    start_req("arst", 3'd3, 7'd8);
    serve("arst rd1", 1'b0, 7'h0E, 16'h0, 16'h5FFF, 1);
    wait_den("arst wr1");
    check("arst wr1 wdata", 32'(drp_di), 32'h5104);
    tick();
    #2 reset_n = 1'b0;
    #1 check_quiet("arst mid-sequence");
    tick(2);
    reset_n = 1'b1;
    tick();
    run_valid("after arst", 3'd3, 7'd8, 7'h0E, 7'h0F, 16'h5FFF, 16'h5104, 16'h12FF, 16'h1200, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
